// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Detects load-use hazards against the load in EX plus a (LOAD_LAT-1)-deep
// pending-load shift register. Control redirects flush IF/ID and ID/EX.
// Cache misses freeze the whole pipeline through a two-state miss FSM,
// which also times out into a sticky miss_err.
// Optional macro HAZARD_PERF_EN: enables the saturating performance counters.
// Without it the counter ports are tied to zero.
//
// Handshake: mem_req/mem_ready is a strict valid/ready pair. An access
// completes in the cycle where both are high. mem_ready alone in WAIT
// ends the miss.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int MISS_TIMEOUT = 256,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              memwb_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              miss_err,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  miss_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int SB_N = LOAD_LAT - 1;
  localparam int WCW  = (MISS_TIMEOUT > 2) ? $clog2(MISS_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MISS_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } miss_state_t;

  miss_state_t    state;
  logic [WCW-1:0] wait_cnt;
  logic           frozen;
  logic           ex_load;
  logic           sb_hit1;
  logic           sb_hit2;
  logic           rs1_hit;
  logic           rs2_hit;
  logic           lu_hit;

  // A miss freezes from its first cycle and ends on the mem_ready cycle.
  assign frozen  = ((state == S_IDLE) && mem_req && !mem_ready) ||
                   ((state == S_WAIT) && !mem_ready);
  assign ex_load = ex_memread && (ex_rd != '0);

  // Miss FSM with wait counter; miss_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      miss_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (mem_req && !mem_ready) state <= S_WAIT;
        end
        default: begin
          if (wait_cnt == WAIT_LAST) miss_err <= 1'b1;
          else                       wait_cnt <= wait_cnt + WCW'(1);
          if (mem_ready) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end
        end
      endcase
    end
  end

  generate
    if (SB_N > 0) begin : g_sb
      logic [SB_N-1:0]   sb_vld;
      logic [REG_AW-1:0] sb_rd [SB_N];

      // Pending-load shift register; time stands still while frozen.
      always_ff @(posedge clk) begin
        if (rst) begin
          sb_vld <= '0;
          for (int k = 0; k < SB_N; k++) sb_rd[k] <= '0;
        end else if (!frozen) begin
          sb_vld[0] <= ex_load;
          sb_rd[0]  <= ex_rd;
          for (int k = 1; k < SB_N; k++) begin
            sb_vld[k] <= sb_vld[k-1];
            sb_rd[k]  <= sb_rd[k-1];
          end
        end
      end

      // Match ID sources against every live scoreboard entry.
      always_comb begin
        sb_hit1 = 1'b0;
        sb_hit2 = 1'b0;
        for (int k = 0; k < SB_N; k++) begin
          if (sb_vld[k] && (sb_rd[k] == id_rs1)) sb_hit1 = 1'b1;
          if (sb_vld[k] && (sb_rd[k] == id_rs2)) sb_hit2 = 1'b1;
        end
      end
    end else begin : g_nosb
      assign sb_hit1 = 1'b0;
      assign sb_hit2 = 1'b0;
    end
  endgenerate

  assign rs1_hit = id_rs1_used && (id_rs1 != '0) &&
                   ((ex_load && (ex_rd == id_rs1)) || sb_hit1);
  assign rs2_hit = id_rs2_used && (id_rs2 != '0) &&
                   ((ex_load && (ex_rd == id_rs2)) || sb_hit2);
  assign lu_hit  = rs1_hit || rs2_hit;

  // Prioritised stall/flush decode: reset, freeze, redirect, load-use.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (frozen) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hit) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic             lu_sel;
  logic             fl_sel;
  logic [CNT_W-1:0] lu_q;
  logic [CNT_W-1:0] miss_q;
  logic [CNT_W-1:0] fl_q;

  assign lu_sel = !frozen && !ex_redirect && lu_hit;
  assign fl_sel = !frozen && ex_redirect;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q   <= '0;
      miss_q <= '0;
      fl_q   <= '0;
    end else begin
      if (lu_sel && (lu_q != '1))   lu_q   <= lu_q + CNT_W'(1);
      if (frozen && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
      if (fl_sel && (fl_q != '1))   fl_q   <= fl_q + CNT_W'(1);
    end
  end

  assign lu_stall_cnt   = lu_q;
  assign miss_stall_cnt = miss_q;
  assign flush_cnt      = fl_q;
`else
  assign lu_stall_cnt   = '0;
  assign miss_stall_cnt = '0;
  assign flush_cnt      = '0;
`endif

endmodule
